// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c_write16 engine between requesters
// Optional transaction watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                  i2c_clk2,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*7-1:0]  req_addr,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [2:0]            req_nack,
  output logic                  busy,
  output logic                  timeout,
  output logic                  eng_en,
  input  logic                  eng_done,
  output logic [6:0]            eng_addr,
  output logic [15:0]           eng_data,
  input  logic [2:0]            eng_nack
);

  localparam int               PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]    LAST = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt, gidx, gidx_nxt, win, cand;
  logic               found, expire;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic [2:0]         nack_nxt;
  logic [6:0]         addr_nxt;
  logic [15:0]        data_nxt;
  logic               en_nxt;
  int                 idx_i;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic        to_q, to_nxt;
  assign timeout = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_i = 0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_i = int'(ptr) + off;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      cand = idx_i[PW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    grant_nxt = req_grant;
    done_nxt  = '0;
    nack_nxt  = req_nack;
    addr_nxt  = eng_addr;
    data_nxt  = eng_data;
    en_nxt    = eng_en;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_inc   = cnt + 16'd1;
    cnt_nxt   = cnt;
    to_nxt    = to_q;
    expire    = !eng_done && (cnt_inc == TIMEOUT_CYCLES);
`else
    expire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        en_nxt    = 1'b0;
        grant_nxt = '0;
        if (found) begin
          gidx_nxt  = win;
          grant_nxt = ONE << win;
          addr_nxt  = req_addr[int'(win)*7 +: 7];
          data_nxt  = req_data[int'(win)*16 +: 16];
          en_nxt    = 1'b1;
          state_nxt = ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_nxt   = 16'd0;
`endif
        end
      end
      ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_nxt = cnt_inc;
        to_nxt  = to_q | expire;
`endif
        if (eng_done || expire) begin
          en_nxt    = 1'b0;
          done_nxt  = ONE << gidx;
          nack_nxt  = expire ? 3'b111 : eng_nack;
          ptr_nxt   = (gidx == LAST) ? '0 : gidx + 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Extra idle cycle so the engine sees eng_en low long enough to re-arm.
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge i2c_clk2 or negedge enable) begin
    if (!enable) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      req_grant <= '0;
      req_done  <= '0;
      req_nack  <= 3'b000;
      eng_addr  <= 7'd0;
      eng_data  <= 16'd0;
      eng_en    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt       <= 16'd0;
      to_q      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gidx      <= gidx_nxt;
      req_grant <= grant_nxt;
      req_done  <= done_nxt;
      req_nack  <= nack_nxt;
      eng_addr  <= addr_nxt;
      eng_data  <= data_nxt;
      eng_en    <= en_nxt;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt       <= cnt_nxt;
      to_q      <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - scoreboard bench for i2c_arbiter with a simple engine model
`timescale 1ns/1ps
module tb_i2c_arbiter;

  localparam int N = 4;

  logic            i2c_clk2 = 1'b0;
  logic            enable   = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*7-1:0]  req_addr  = '0;
  logic [N*16-1:0] req_data  = '0;
  logic [N-1:0]    req_grant, req_done;
  logic [2:0]      req_nack;
  logic            busy, timeout, eng_en;
  logic            eng_done = 1'b0;
  logic [6:0]      eng_addr;
  logic [15:0]     eng_data;
  logic [2:0]      eng_nack = 3'b000;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16'd16)) dut (
    .i2c_clk2(i2c_clk2), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done), .req_nack(req_nack),
    .busy(busy), .timeout(timeout),
    .eng_en(eng_en), .eng_done(eng_done), .eng_addr(eng_addr),
    .eng_data(eng_data), .eng_nack(eng_nack)
  );

  always #5 i2c_clk2 = ~i2c_clk2;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [15:0] data;
    logic [2:0] nack;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int         eng_lat      = 20;
  logic [2:0] eng_nack_cfg = 3'b000;
  bit         eng_hang     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input int idx, input logic [2:0] nack, input logic to);
    exp_t e;
    e.idx  = idx;
    e.addr = req_addr[idx*7 +: 7];
    e.data = req_data[idx*16 +: 16];
    e.nack = nack;
    e.to   = to;
    sb.push_back(e);
  endtask

  task automatic wait_dones(input int n, input bit keep, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(posedge i2c_clk2);
      if (req_done != '0) begin
        got++;
        if (!keep) req_valid = req_valid & ~req_done;
      end
    end
    if (got < n) check("done_wait", got, n);
    req_valid = '0;
  endtask

  task automatic wait_grant(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge i2c_clk2);
      if (req_grant[idx]) seen = 1'b1;
    end
    if (!seen) check("grant_wait", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge i2c_clk2);
    enable = 1'b0;
    sb.delete();
    req_valid = '0;
    repeat (3) @(posedge i2c_clk2);
    enable = 1'b1;
    repeat (2) @(posedge i2c_clk2);
  endtask

  // Engine: after eng_en has been high for eng_lat cycles, pulse done until eng_en drops.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge i2c_clk2);
      if (!enable || !eng_en) begin
        cnt = 0;
        eng_done = 1'b0;
      end else if (!eng_done) begin
        cnt++;
        if (!eng_hang && cnt >= eng_lat) begin
          eng_done = 1'b1;
          eng_nack = eng_nack_cfg;
        end
      end
    end
  end

  // Monitor: compare grants and completions against the scoreboard.
  initial begin
    logic [N-1:0] prev_grant;
    int           low_cnt;
    bit           post_done;
    exp_t         e;
    prev_grant = '0;
    low_cnt    = 100;
    post_done  = 1'b0;
    forever begin
      @(posedge i2c_clk2);
      if (!enable) begin
        prev_grant = '0;
        low_cnt    = 100;
        post_done  = 1'b0;
      end else begin
        if (post_done) begin
          check("release_idle", {busy, eng_en, req_grant, req_done}, 0);
          post_done = 1'b0;
        end
        if (req_grant != '0 && prev_grant == '0) begin
          if (sb.size() == 0) check("spurious_grant", req_grant, 0);
          else begin
            e = sb[0];
            check("grant", req_grant, 32'(1) << e.idx);
            check("eng_addr", eng_addr, e.addr);
            check("eng_data", eng_data, e.data);
            check("en_busy_on_grant", {eng_en, busy}, 2'b11);
            check("en_low_gap", low_cnt >= 2, 1);
          end
        end
        if (req_done != '0) begin
          if (sb.size() == 0) check("spurious_done", req_done, 0);
          else begin
            e = sb.pop_front();
            check("done", req_done, 32'(1) << e.idx);
            check("grant_at_done", req_grant, 32'(1) << e.idx);
            check("nack", req_nack, e.nack);
            check("timeout_flag", timeout, e.to);
            check("en_busy_at_done", {eng_en, busy}, 2'b01);
          end
          post_done = 1'b1;
        end
        if (eng_en) low_cnt = 0;
        else low_cnt++;
        prev_grant = req_grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*7 +: 7]   = 7'(7'h10 + i * 7'h11);
      req_data[i*16 +: 16] = 16'(16'h1000 + i * 16'h0123);
    end
    req_addr[1*7 +: 7]   = 7'h39;
    req_data[1*16 +: 16] = 16'h4110;

    repeat (3) @(posedge i2c_clk2);
    check("reset_outputs", {eng_en, eng_addr, eng_data, req_grant, req_done, req_nack, busy, timeout}, 0);
    enable = 1'b1;
    repeat (2) @(posedge i2c_clk2);

    // Single requester with grant latency.
    eng_lat = 20; eng_nack_cfg = 3'b000;
    expect_txn(1, 3'b000, 1'b0);
    req_valid = 4'b0010;
    @(posedge i2c_clk2);
    check("grant_latency", {req_grant, eng_en, busy}, {4'b0010, 2'b11});
    wait_dones(1, 1'b0, 200);
    repeat (3) @(posedge i2c_clk2);

    // NACK pass-through and hold.
    eng_lat = 5; eng_nack_cfg = 3'b010;
    expect_txn(2, 3'b010, 1'b0);
    req_valid = 4'b0100;
    wait_dones(1, 1'b0, 100);
    repeat (4) @(posedge i2c_clk2);
    check("nack_hold", req_nack, 3'b010);

    // Requester drops valid after grant; transaction still completes.
    eng_lat = 10; eng_nack_cfg = 3'b000;
    expect_txn(3, 3'b000, 1'b0);
    req_valid = 4'b1000;
    wait_grant(3, 20);
    req_valid = '0;
    wait_dones(1, 1'b0, 100);
    repeat (2) @(posedge i2c_clk2);

    // Move ptr to 2, then reset mid-ISSUE and check the scan restarts at 0.
    eng_lat = 4;
    expect_txn(1, 3'b000, 1'b0);
    req_valid = 4'b0010;
    wait_dones(1, 1'b0, 100);
    repeat (2) @(posedge i2c_clk2);
    eng_hang = 1'b1;
    expect_txn(3, 3'b000, 1'b0);
    req_valid = 4'b1000;
    wait_grant(3, 20);
    repeat (3) @(posedge i2c_clk2);
    enable = 1'b0;
    #1;
    check("reset_mid_issue", {eng_en, eng_addr, eng_data, req_grant, req_done, req_nack, busy, timeout}, 0);
    sb.delete();
    req_valid = '0;
    eng_hang = 1'b0;
    repeat (3) @(posedge i2c_clk2);
    enable = 1'b1;
    repeat (2) @(posedge i2c_clk2);
    expect_txn(0, 3'b000, 1'b0);
    expect_txn(2, 3'b000, 1'b0);
    req_valid = 4'b0101;
    wait_dones(2, 1'b0, 200);
    repeat (2) @(posedge i2c_clk2);

    // Round-robin with every requester held valid.
    do_reset();
    eng_lat = 3;
    expect_txn(0, 3'b000, 1'b0);
    expect_txn(1, 3'b000, 1'b0);
    expect_txn(2, 3'b000, 1'b0);
    expect_txn(3, 3'b000, 1'b0);
    expect_txn(0, 3'b000, 1'b0);
    req_valid = 4'b1111;
    wait_dones(5, 1'b1, 500);
    repeat (4) @(posedge i2c_clk2);
    check("rr_drained", sb.size(), 0);
    check("rr_idle", {busy, req_grant}, 0);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: engine never completes.
    begin
      int n;
      bit seen;
      eng_hang = 1'b1;
      expect_txn(1, 3'b111, 1'b1);
      req_valid = 4'b0010;
      wait_grant(1, 20);
      n = 0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(posedge i2c_clk2);
        n++;
        if (req_done != '0) seen = 1'b1;
      end
      req_valid = '0;
      check("wd_cycles", n, 16);
      repeat (5) @(posedge i2c_clk2);
      check("wd_sticky", timeout, 1);
      eng_hang = 1'b0;
      do_reset();
      check("wd_cleared", timeout, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
